// File: rtl/sdram_chip_model_if.sv
// SDRAM command/data bus between a controller and the chip model.
// The controller drives commands and write data; the model answers.
interface sdram_chip_model_if #(
  parameter int DQ_W = 16
);
  logic            sdram_cke;
  logic            sdram_cs_n;
  logic            sdram_ras_n;
  logic            sdram_cas_n;
  logic            sdram_we_n;
  logic [1:0]      sdram_ba;
  logic [12:0]     sdram_addr;
  logic [DQ_W-1:0] dq_in;
  logic [DQ_W-1:0] dq_out;
  logic            dq_oe;
  logic [12:0]     mode_reg;
  logic            mode_valid;
  logic [15:0]     refresh_cnt;
  logic            proto_err;
  logic [2:0]      err_code;

  modport master (
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n,
    output sdram_we_n, sdram_ba, sdram_addr, dq_in,
    input  dq_out, dq_oe, mode_reg, mode_valid,
    input  refresh_cnt, proto_err, err_code
  );

  modport slave (
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n,
    input  sdram_we_n, sdram_ba, sdram_addr, dq_in,
    output dq_out, dq_oe, mode_reg, mode_valid,
    output refresh_cnt, proto_err, err_code
  );
endinterface

// File: rtl/sdram_chip_model.sv
// Cycle-accurate 4-bank SDRAM responder: mode register, open rows,
// timing windows, CL read pipeline, burst writes, violation capture.
module sdram_chip_model #(
  parameter int DQ_W  = 16,
  parameter int ROW_W = 2,
  parameter int TRCD  = 2,
  parameter int TRP   = 2,
  parameter int TRFC  = 7
) (
  input  logic clk_100m,
  input  logic rst_n,
  sdram_chip_model_if.slave bus
);
  localparam int AW = 2 + ROW_W + 9;

  typedef enum logic [2:0] {
    C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_MRS, C_BST
  } cmd_e;

  typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} bst_e;

  logic [DQ_W-1:0] mem [2**AW];

  bst_e                  st_q, st_d;
  logic [8:0]            col_q, col_d;
  logic [9:0]            left_q, left_d;
  logic [1:0]            bba_q, bba_d;
  logic [ROW_W-1:0]      brow_q, brow_d;
  logic [3:0]            open_q, open_d;
  logic [3:0][ROW_W-1:0] row_q, row_d;
  logic [3:0][3:0]       trcd_q, trcd_d;
  logic [3:0]            trp_q, trp_d;
  logic [3:0]            trfc_q, trfc_d;
  logic [12:0]           mode_q, mode_d;
  logic                  mv_q, mv_d;
  logic [15:0]           ref_q, ref_d;
  logic                  err_q, err_d;
  logic [2:0]            code_q, code_d;
  logic                  p1_v_q, p1_v_d;
  logic                  p1_cl3_q, p1_cl3_d;
  logic                  p2_v_q, p2_v_d;
  logic [AW-1:0]         p1_idx_q, p1_idx_d;
  logic [AW-1:0]         p2_idx_q, p2_idx_d;
  logic                  oe_q, oe_d;
  logic [DQ_W-1:0]       dq_q, dq_d;

  cmd_e          cmd;
  logic [1:0]    ba;
  logic [8:0]    ccol;
  logic [9:0]    bl_m1;
  logic          cl3;
  logic          cl_ok;
  logic          any_open;
  logic          rf_busy;
  logic [2:0]    fault;
  logic          iss;
  logic          wr_en;
  logic          rd_v;
  logic [AW-1:0] iss_idx;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign ba       = bus.sdram_ba;
  assign ccol     = bus.sdram_addr[8:0];
  assign cl3      = (mode_q[6:4] == 3'd3);
  assign cl_ok    = (bus.sdram_addr[6:4] == 3'd2) ||
                    (bus.sdram_addr[6:4] == 3'd3);
  assign any_open = |open_q;
  assign rf_busy  = (trfc_q != 4'd0);

  always_comb begin
    cmd = C_NOP;
    if (bus.sdram_cke && !bus.sdram_cs_n) begin
      unique case ({bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n})
        3'b011:  cmd = C_ACT;
        3'b101:  cmd = C_RD;
        3'b100:  cmd = C_WR;
        3'b010:  cmd = C_PRE;
        3'b001:  cmd = C_REF;
        3'b000:  cmd = C_MRS;
        3'b110:  cmd = C_BST;
        default: cmd = C_NOP;
      endcase
    end
  end

  always_comb begin
    unique case (mode_q[2:0])
      3'b001:  bl_m1 = 10'd1;
      3'b010:  bl_m1 = 10'd3;
      3'b011:  bl_m1 = 10'd7;
      3'b111:  bl_m1 = 10'd511;
      default: bl_m1 = 10'd0;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    col_d   = col_q;
    left_d  = left_q;
    bba_d   = bba_q;
    brow_d  = brow_q;
    open_d  = open_q;
    row_d   = row_q;
    mode_d  = mode_q;
    mv_d    = mv_q;
    ref_d   = ref_q;
    err_d   = err_q;
    code_d  = code_q;
    fault   = 3'd0;
    iss     = 1'b0;
    wr_en   = 1'b0;
    iss_idx = {bba_q, brow_q, col_q};
    wr_idx  = {bba_q, brow_q, col_q};
    trp_d   = (trp_q != 4'd0) ? trp_q - 4'd1 : 4'd0;
    trfc_d  = (trfc_q != 4'd0) ? trfc_q - 4'd1 : 4'd0;
    for (int i = 0; i < 4; i++) begin
      trcd_d[i] = (trcd_q[i] != 4'd0) ? trcd_q[i] - 4'd1 : 4'd0;
    end

    // Running burst emits one column per cycle unless a command below ends it
    if (st_q != B_IDLE) begin
      iss    = (st_q == B_READ);
      wr_en  = (st_q == B_WRITE);
      col_d  = col_q + 9'd1;
      left_d = left_q - 10'd1;
      if (left_q == 10'd1) st_d = B_IDLE;
    end

    unique case (cmd)
      C_ACT: begin
        if (open_q[ba] || trp_q != 4'd0 || rf_busy) begin
          fault = 3'd3;
        end else begin
          open_d[ba] = 1'b1;
          row_d[ba]  = bus.sdram_addr[ROW_W-1:0];
          trcd_d[ba] = 4'(TRCD - 1);
        end
      end
      C_RD, C_WR: begin
        if (rf_busy) begin
          fault = 3'd5;
        end else if (!open_q[ba] || !mv_q || trcd_q[ba] != 4'd0) begin
          fault = 3'd4;
        end else begin
          bba_d  = ba;
          brow_d = row_q[ba];
          col_d  = ccol + 9'd1;
          left_d = bl_m1;
          if (cmd == C_RD) begin
            iss     = 1'b1;
            wr_en   = 1'b0;
            iss_idx = {ba, row_q[ba], ccol};
            st_d    = (bl_m1 != 10'd0) ? B_READ : B_IDLE;
          end else begin
            iss    = 1'b0;
            wr_en  = 1'b1;
            wr_idx = {ba, row_q[ba], ccol};
            st_d   = (mode_q[9] || bl_m1 == 10'd0) ? B_IDLE : B_WRITE;
          end
        end
      end
      C_PRE: begin
        if (rf_busy) begin
          fault = 3'd5;
        end else begin
          if (bus.sdram_addr[10]) open_d = 4'd0;
          else open_d[ba] = 1'b0;
          trp_d = 4'(TRP - 1);
          if (bus.sdram_addr[10] || ba == bba_q) begin
            st_d  = B_IDLE;
            iss   = 1'b0;
            wr_en = 1'b0;
          end
        end
      end
      C_REF: begin
        if (any_open || trp_q != 4'd0 || rf_busy) begin
          fault = 3'd5;
        end else begin
          ref_d  = ref_q + 16'd1;
          trfc_d = 4'(TRFC - 1);
        end
      end
      C_MRS: begin
        if (rf_busy) fault = 3'd5;
        else if (any_open) fault = 3'd1;
        else if (!cl_ok) fault = 3'd2;
        else begin
          mode_d = bus.sdram_addr;
          mv_d   = 1'b1;
        end
      end
      C_BST: begin
        if (rf_busy) begin
          fault = 3'd5;
        end else begin
          st_d  = B_IDLE;
          iss   = 1'b0;
          wr_en = 1'b0;
        end
      end
      default: ;
    endcase

    if (!err_q && fault != 3'd0) begin
      err_d  = 1'b1;
      code_d = fault;
    end
  end

  // CL=2 data leaves from stage 1, CL=3 from stage 2
  always_comb begin
    p1_v_d   = iss;
    p1_idx_d = iss_idx;
    p1_cl3_d = cl3;
    p2_v_d   = p1_v_q && p1_cl3_q;
    p2_idx_d = p1_idx_q;
    rd_v     = p2_v_q || (p1_v_q && !p1_cl3_q);
    rd_idx   = p2_v_q ? p2_idx_q : p1_idx_q;
    oe_d     = rd_v;
    dq_d     = '0;
    if (rd_v) begin
      dq_d = (wr_en && wr_idx == rd_idx) ? bus.dq_in : mem[rd_idx];
    end
  end

  always_ff @(posedge clk_100m) begin
    if (wr_en) mem[wr_idx] <= bus.dq_in;
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= B_IDLE;
      col_q    <= '0;
      left_q   <= '0;
      bba_q    <= '0;
      brow_q   <= '0;
      open_q   <= '0;
      row_q    <= '0;
      trcd_q   <= '0;
      trp_q    <= '0;
      trfc_q   <= '0;
      mode_q   <= '0;
      mv_q     <= 1'b0;
      ref_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
      p1_v_q   <= 1'b0;
      p1_cl3_q <= 1'b0;
      p1_idx_q <= '0;
      p2_v_q   <= 1'b0;
      p2_idx_q <= '0;
      oe_q     <= 1'b0;
      dq_q     <= '0;
    end else begin
      st_q     <= st_d;
      col_q    <= col_d;
      left_q   <= left_d;
      bba_q    <= bba_d;
      brow_q   <= brow_d;
      open_q   <= open_d;
      row_q    <= row_d;
      trcd_q   <= trcd_d;
      trp_q    <= trp_d;
      trfc_q   <= trfc_d;
      mode_q   <= mode_d;
      mv_q     <= mv_d;
      ref_q    <= ref_d;
      err_q    <= err_d;
      code_q   <= code_d;
      p1_v_q   <= p1_v_d;
      p1_cl3_q <= p1_cl3_d;
      p1_idx_q <= p1_idx_d;
      p2_v_q   <= p2_v_d;
      p2_idx_q <= p2_idx_d;
      oe_q     <= oe_d;
      dq_q     <= dq_d;
    end
  end

  assign bus.dq_out      = dq_q;
  assign bus.dq_oe       = oe_q;
  assign bus.mode_reg    = mode_q;
  assign bus.mode_valid  = mv_q;
  assign bus.refresh_cnt = ref_q;
  assign bus.proto_err   = err_q;
  assign bus.err_code    = code_q;
endmodule
